// File: rtl/nfu_2_acc.sv
// NFU-2: registered adder tree per neuron feeding a tile accumulator.
// Define NFU2_OUT_SAT_EN to clamp outputs instead of truncating them.
module nfu_2_acc #(
  parameter int N     = 16,
  parameter int Tn    = 16,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [Tn*Tn*N-1:0]   i_nfu1_out,
  input  logic                 i_valid,
  input  logic                 i_first,
  input  logic                 i_last,
  output logic [Tn*N-1:0]      o_nfu2_out,
  output logic                 o_valid
);

  localparam int L  = $clog2(Tn);
  localparam int SW = N + L;

  logic [Tn*SW-1:0] tsum;

  genvar gi, gk;
  for (gi = 0; gi < Tn; gi++) begin : g_n
    for (gk = 0; gk <= L; gk++) begin : g_l
      localparam int W = N + gk;
      localparam int C = Tn >> gk;
      logic [C*W-1:0] v;
      if (gk == 0) begin : g_in
        assign v = i_nfu1_out[gi*Tn*N +: Tn*N];
      end else begin : g_add
        logic [C*W-1:0] d;
        logic [W-2:0]   a;
        logic [W-2:0]   b;
        // each pair is sign-extended by one bit so the sum cannot overflow
        always_comb begin
          d = '0;
          a = '0;
          b = '0;
          for (int j = 0; j < C; j++) begin
            a = g_l[gk-1].v[(2*j)*(W-1) +: W-1];
            b = g_l[gk-1].v[(2*j+1)*(W-1) +: W-1];
            d[j*W +: W] = {a[W-2], a} + {b[W-2], b};
          end
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) v <= '0;
          else        v <= d;
        end
      end
    end
    assign tsum[gi*SW +: SW] = g_l[L].v;
  end

  logic [L-1:0] sv_q;
  logic [L-1:0] sf_q;
  logic [L-1:0] sl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q <= '0;
      sf_q <= '0;
      sl_q <= '0;
    end else begin
      sv_q[0] <= i_valid;
      sf_q[0] <= i_valid & i_first;
      sl_q[0] <= i_valid & i_last;
      for (int m = 1; m < L; m++) begin
        sv_q[m] <= sv_q[m-1];
        sf_q[m] <= sf_q[m-1];
        sl_q[m] <= sl_q[m-1];
      end
    end
  end

  logic [Tn*ACC_W-1:0] acc_q;
  logic [Tn*ACC_W-1:0] acc_d;
  logic signed [SW-1:0]    ts;
  logic signed [ACC_W-1:0] ext;

  always_comb begin
    acc_d = acc_q;
    ts    = '0;
    ext   = '0;
    for (int i = 0; i < Tn; i++) begin
      ts  = signed'(tsum[i*SW +: SW]);
      ext = ACC_W'(ts);
      if (sv_q[L-1]) begin
        acc_d[i*ACC_W +: ACC_W] =
          (sf_q[L-1] ? '0 : acc_q[i*ACC_W +: ACC_W]) + ext;
      end
    end
  end

  logic                    done_q;
  logic [Tn*N-1:0]         out_q;
  logic [Tn*N-1:0]         out_d;
  logic                    vld_q;
  logic signed [ACC_W-1:0] as;

  always_comb begin
    out_d = '0;
    as    = '0;
    for (int i = 0; i < Tn; i++) begin
      as = signed'(acc_q[i*ACC_W +: ACC_W]);
`ifdef NFU2_OUT_SAT_EN
      if (as > signed'({{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}}))
        out_d[i*N +: N] = {1'b0, {(N-1){1'b1}}};
      else if (as < signed'({{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}}))
        out_d[i*N +: N] = {1'b1, {(N-1){1'b0}}};
      else
        out_d[i*N +: N] = as[N-1:0];
`else
      out_d[i*N +: N] = as[N-1:0];
`endif
    end
  end

  // output narrows the acc value one edge after the closing update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      done_q <= 1'b0;
      out_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      done_q <= sv_q[L-1] & sl_q[L-1];
      vld_q  <= done_q;
      if (done_q) out_q <= out_d;
    end
  end

  assign o_nfu2_out = out_q;
  assign o_valid    = vld_q;

endmodule

// File: tb/tb_nfu_2_acc.sv
// Randomized bench for nfu_2_acc against a per-beat sum/accumulate model.
// Expected narrowing follows NFU2_OUT_SAT_EN when it is defined.
module tb_nfu_2_acc;

  localparam int N   = 16;
  localparam int TN  = 16;
  localparam int LAT = 6;
  localparam int OW  = TN * N;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TN*OW-1:0] i_nfu1_out;
  logic            i_valid;
  logic            i_first;
  logic            i_last;
  logic [OW-1:0]   o_nfu2_out;
  logic            o_valid;

  nfu_2_acc #(.N(N), .Tn(TN), .ACC_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_nfu1_out (i_nfu1_out),
    .i_valid    (i_valid),
    .i_first    (i_first),
    .i_last     (i_last),
    .o_nfu2_out (o_nfu2_out),
    .o_valid    (o_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] d;
    int            t;
  } exp_t;

  exp_t          q[$];
  int            acc_m[TN];
  logic [OW-1:0] held;
  int            total = 0;
  int            bad = 0;
  bit            started = 0;
  bit            ev;

  task automatic chk(string tag, logic [OW-1:0] got,
                     logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] nar(int a);
`ifdef NFU2_OUT_SAT_EN
    if (a > 32767)  return 16'h7fff;
    if (a < -32768) return 16'h8000;
`endif
    return a[N-1:0];
  endfunction

  // mode 0: every product = val; 1: neuron 0 only; 2: random
  task automatic send(bit v, bit f, bit l, int mode, int val);
    int p;
    int s;
    logic [15:0] r;
    logic [OW-1:0] d;
    @(negedge clk);
    for (int i = 0; i < TN; i++) begin
      s = 0;
      for (int j = 0; j < TN; j++) begin
        r = 16'($urandom);
        case (mode)
          0:       p = val;
          1:       p = (i == 0) ? val : 0;
          default: p = int'($signed(r));
        endcase
        s += p;
        i_nfu1_out[(i*TN+j)*N +: N] = N'(p);
      end
      if (v) begin
        if (f) acc_m[i] = 0;
        acc_m[i] += s;
      end
    end
    i_valid = v;
    i_first = f;
    i_last  = l;
    if (v && l) begin
      d = '0;
      for (int i = 0; i < TN; i++) d[i*N +: N] = nar(acc_m[i]);
      q.push_back('{d, cyc + LAT});
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) send(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
    q.delete();
    held    = '0;
    for (int i = 0; i < TN; i++) acc_m[i] = 0;
    started = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    #1;
    if (started) begin
      ev = (q.size() > 0) && (q[0].t == cyc);
      chk("o_valid", OW'(o_valid), OW'(ev));
      if (ev) begin
        held = q[0].d;
        void'(q.pop_front());
      end
      chk("o_nfu2_out", o_nfu2_out, held);
    end
  end

  initial begin
    rst_n      = 1'b1;
    i_valid    = 1'b0;
    i_first    = 1'b0;
    i_last     = 1'b0;
    i_nfu1_out = '0;
    held       = '0;
    for (int i = 0; i < TN; i++) acc_m[i] = 0;
    do_reset();
    chk("rst_out", o_nfu2_out, '0);

    send(1, 1, 1, 0, 1);
    idle(8);
    chk("single", o_nfu2_out, {TN{16'h0010}});

    send(1, 1, 0, 1, 1);
    send(1, 0, 0, 1, 2);
    send(1, 0, 1, 1, -1);
    idle(8);
    chk("three", o_nfu2_out, {{(TN-1){16'h0000}}, 16'h0020});

    send(1, 1, 0, 1, 1);
    idle(3);
    send(1, 0, 0, 1, 2);
    idle(3);
    send(1, 0, 1, 1, -1);
    idle(8);
    chk("bubbles", o_nfu2_out, {{(TN-1){16'h0000}}, 16'h0020});

    send(1, 1, 0, 0, 32767);
    send(1, 0, 0, 0, 32767);
    send(1, 0, 0, 0, 32767);
    send(1, 0, 1, 0, 32767);
    idle(8);
`ifdef NFU2_OUT_SAT_EN
    chk("ovf_pos", o_nfu2_out, {TN{16'h7fff}});
`else
    chk("ovf_pos", o_nfu2_out, {TN{16'hffc0}});
`endif
    send(1, 1, 1, 0, -32768);
    idle(8);
`ifdef NFU2_OUT_SAT_EN
    chk("ovf_neg", o_nfu2_out, {TN{16'h8000}});
`else
    chk("ovf_neg", o_nfu2_out, {TN{16'h0000}});
`endif

    send(1, 1, 1, 0, 1);
    send(1, 1, 1, 0, 3);
    idle(8);
    chk("b2b", o_nfu2_out, {TN{16'h0030}});

    send(1, 1, 1, 0, 5);
    idle(2);
    do_reset();
    chk("midrst", o_nfu2_out, '0);
    idle(8);
    send(1, 1, 1, 0, 1);
    idle(8);
    chk("post_rst", o_nfu2_out, {TN{16'h0010}});

    for (int k = 0; k < 400; k++) begin
      send($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, 2, 0);
    end
    idle(10);
    chk("drain", OW'(q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nfu_2_acc.md
# nfu_2_acc

Pipelined adder-tree and partial-sum accumulator stage (NFU-2) between the NFU-1 multiplier array and the NFU-3 sigmoid stage. Each beat carries Tn×Tn signed products: Tn output neurons, each with Tn synapse products. For each neuron, the block reduces its Tn products through a registered binary adder tree and accumulates the result across input tiles. When the last tile completes, it emits one Tn×N vector of neuron sums to NFU-3.

## Interface
Parameters:
- N, 16, data width of products and outputs (signed two's complement, same fixed-point format)
- Tn, 16, neurons per beat and products per neuron; power of 2, ≥2
- ACC_W, 32, accumulator width; must be ≥ N+log2(Tn)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_nfu1_out  input  Tn*Tn*N  products; neuron i, synapse j at bits [(i*Tn+j+1)*N-1 : (i*Tn+j)*N]
- i_valid  input  1  beat valid
- i_first  input  1  beat is the first tile of a neuron group; qualified by i_valid
- i_last  input  1  beat is the last tile of a neuron group; qualified by i_valid
- o_nfu2_out  output  Tn*N  neuron sums; neuron i at bits [(i+1)*N-1 : i*N]
- o_valid  output  1  one-cycle pulse; o_nfu2_out is new this cycle

## Operation
- **Adder tree.** L = log2(Tn) levels, with a register after every level.
  - Level k sums pairs, and its result is one bit wider than its operands (sign-extended), so there is no overflow inside the tree.
  - The final tree sum is N+L bits per neuron.
- **Sideband.** {valid, first, last} travel in an L-deep shift register aligned with the tree data.
  - first and last are forced to 0 when i_valid is 0.
- **Accumulate stage.** Runs when the aligned valid is 1.
  - acc[i] ← (first ? 0 : acc[i]) + sext(tree_sum[i]), computed in ACC_W bits.
  - The accumulator wraps modulo 2^ACC_W.
  - When the aligned valid is 0, acc holds its value.
- **Output register.** Loads when the accumulate stage sees valid & last.
  - It loads the narrowed value of the updated acc; see Configuration.
  - o_valid is 1 for exactly that cycle.
  - o_nfu2_out holds its value until the next load.
- **Simultaneous first & last.** The output equals that beat's tree sum alone.
- **last with no preceding first.** Accumulation continues on the current acc; acc is 0 after reset.
- **Bubbles.** Gaps of any length with i_valid=0 between first and last do not change the result.
- **Back-to-back groups.** A beat with last followed directly by a beat with first is supported at full rate; the two groups are independent.
- **Flow control.** There is no backpressure. The block accepts one beat per cycle, and the consumer must take every o_valid pulse.

## Timing
- Throughput is 1 beat per cycle.
- **Latency.** If a beat with valid & last is sampled at edge k, o_valid is high in the cycle after edge k+L+1. For Tn=16 that is L+1 = 5 edges.
- **Reset values.** rst_n low asynchronously clears:
  - all tree registers and sideband valid/first/last to 0,
  - acc to 0,
  - o_nfu2_out to 0 and o_valid to 0.
- **Reset mid-operation.** In-flight beats are discarded and no o_valid is produced for them. The first beat accepted after rst_n deasserts is the first beat processed.

## Configuration
- Macro: NFU2_OUT_SAT_EN.
- **Defined.** The output clamps acc to the signed N-bit range, [-2^(N-1), 2^(N-1)-1].
- **Undefined.** The output is acc[N-1:0], truncated with no clamping. This saves the comparators.
- The accumulator and tree behave identically in both builds.

## Test plan
All tests use N=16, Tn=16, ACC_W=32.

1. **Single-beat group.** One beat with first=last=1 and all products 0x0001, at edge k → o_valid high after edge k+5 only; every lane of o_nfu2_out = 0x0010.
2. **Three-tile group.** Neuron-0 products are all 1, then all 2, then all -1 (first on beat 1, last on beat 3); all other products are 0 → lane 0 = 0x0020, other lanes 0x0000, a single o_valid pulse.
3. **Bubbles.** Same as test 2, but with 3 idle cycles (i_valid=0) between each beat → identical result; o_valid comes 5 edges after the last beat.
4. **Overflow.** Four beats, first through last, with all products 0x7FFF → acc = 2097088:
   - With NFU2_OUT_SAT_EN, lanes = 0x7FFF.
   - Without it, lanes = 0xFFC0.
   - A single beat of all 0x8000 → 0x8000 saturated, or 0x0000 truncated.
5. **Back-to-back groups.** A first=last beat of all 1s, immediately followed by a first=last beat of all 3s → o_valid on two consecutive cycles with lanes 0x0010 then 0x0030.
6. **Reset mid-operation.** Pull rst_n low 2 cycles after a last beat → o_valid stays 0 and o_nfu2_out = 0. After release, a single-beat group of all 1s → 0x0010, with no contamination from the discarded beat.
